// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the single-clock ready/valid FIFO.
// Holds default configuration values, the default pointer type and the
// pointer full/empty compare helpers used by fifo_rdy_sync.
// Optional feature macro used by the top: FIFO_PEAK_EN (high-water mark).
package fifo_pkg;

  localparam int unsigned ADDRB_DEF = 5;
  localparam int unsigned WID_DEF   = 32;
  localparam int unsigned CHK_DEF   = 2;

  // Pointer for the default depth: ADDRB address bits plus one wrap bit.
  localparam int unsigned PTR_W_DEF = ADDRB_DEF + 1;
  typedef logic [PTR_W_DEF-1:0] ptr_t;

  // Compare container wide enough for any supported ADDRB; callers zero-extend.
  typedef logic [31:0] ptr_cmp_t;

  // Full: address bits equal, wrap bits differ, i.e. XOR is exactly the wrap bit.
  function automatic logic ptr_full(input ptr_cmp_t wp, input ptr_cmp_t rp,
                                    input int unsigned addrb);
    return (wp ^ rp) == (ptr_cmp_t'(1) << addrb);
  endfunction

  // Empty: both pointers identical, wrap bit included.
  function automatic logic ptr_empty(input ptr_cmp_t wp, input ptr_cmp_t rp);
    return wp == rp;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEP x WID storage for fifo_rdy_sync.
// Ports:
//   clk   - clock
//   i_we  - write enable
//   i_wa  - write address
//   i_wd  - write data
//   i_ra  - read address
//   o_rd  - read data (asynchronous, mem[i_ra])
// The array has no reset; contents are only meaningful once written.
module fifo_ram #(
  parameter int unsigned ADDRB = 5,
  parameter int unsigned WID   = 32
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [ADDRB-1:0] i_wa,
  input  logic [WID-1:0]   i_wd,
  input  logic [ADDRB-1:0] i_ra,
  output logic [WID-1:0]   o_rd
);

  localparam int unsigned DEP = 1 << ADDRB;

  logic [WID-1:0] r_mem [DEP];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/fifo_rdy_sync.sv
// fifo_rdy_sync: single-clock first-word-fall-through ready/valid FIFO.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   fifowr     - write strobe, fifodi write data
//   fifoget    - pop head entry
//   flush      - synchronous clear of contents (below rst, above wr/get)
//   reqen      - enable for fifordy
//   fifodout   - head data, valid while fifovld
//   fifovld    - non-empty
//   fifordy    - reqen && free entries >= CHK
//   fifofull   - occupancy == DEP
//   fifoafull  - occupancy >= AFTHR
//   fifowrerr  - one-cycle pulse after a write while full
//   fiforderr  - one-cycle pulse after a get while empty
//   fifolen    - occupancy 0..DEP
//   fifopeak   - high-water mark of fifolen (only with FIFO_PEAK_EN)
// Macro: FIFO_PEAK_EN adds the fifopeak output and its register.
module fifo_rdy_sync
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRB = ADDRB_DEF,
  parameter int unsigned WID   = WID_DEF,
  parameter int unsigned CHK   = CHK_DEF,
  parameter int unsigned AFTHR = (1 << ADDRB) - 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fifowr,
  input  logic [WID-1:0] fifodi,
  input  logic           fifoget,
  input  logic           flush,
  input  logic           reqen,
  output logic [WID-1:0] fifodout,
  output logic           fifovld,
  output logic           fifordy,
  output logic           fifofull,
  output logic           fifoafull,
  output logic           fifowrerr,
  output logic           fiforderr,
  output logic [ADDRB:0] fifolen
`ifdef FIFO_PEAK_EN
  ,
  output logic [ADDRB:0] fifopeak
`endif
);

  localparam logic [ADDRB:0] DEP_V   = {1'b1, {ADDRB{1'b0}}};
  localparam logic [ADDRB:0] CHK_V   = CHK[ADDRB:0];
  localparam logic [ADDRB:0] AFTHR_V = AFTHR[ADDRB:0];
  localparam logic [ADDRB:0] PONE    = {{ADDRB{1'b0}}, 1'b1};

  logic [ADDRB:0] r_wrptr, r_rdptr, r_len;
  logic [ADDRB:0] w_wrptr_d, w_rdptr_d, w_len_d;
  logic           r_wrerr, r_rderr;
  logic           r_rdy_en;
  logic           w_full, w_empty;
  logic           w_wr_acc, w_get_acc;
  logic [ADDRB:0] w_free;

  assign w_full  = ptr_full(ptr_cmp_t'(r_wrptr), ptr_cmp_t'(r_rdptr), ADDRB);
  assign w_empty = ptr_empty(ptr_cmp_t'(r_wrptr), ptr_cmp_t'(r_rdptr));

  // A write while full is dropped even if a get frees a slot this cycle.
  assign w_wr_acc  = fifowr && !w_full;
  assign w_get_acc = fifoget && !w_empty;

  always_comb begin
    w_wrptr_d = r_wrptr;
    w_rdptr_d = r_rdptr;
    w_len_d   = r_len;
    if (flush) begin
      w_wrptr_d = '0;
      w_rdptr_d = '0;
      w_len_d   = '0;
    end else begin
      if (w_wr_acc) begin
        w_wrptr_d = r_wrptr + PONE;
      end
      if (w_get_acc) begin
        w_rdptr_d = r_rdptr + PONE;
      end
      case ({w_wr_acc, w_get_acc})
        2'b10:   w_len_d = r_len + PONE;
        2'b01:   w_len_d = r_len - PONE;
        default: w_len_d = r_len;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrptr  <= '0;
      r_rdptr  <= '0;
      r_len    <= '0;
      r_wrerr  <= 1'b0;
      r_rderr  <= 1'b0;
      r_rdy_en <= 1'b0;
    end else begin
      r_wrptr  <= w_wrptr_d;
      r_rdptr  <= w_rdptr_d;
      r_len    <= w_len_d;
      r_wrerr  <= !flush && fifowr && w_full;
      r_rderr  <= !flush && fifoget && w_empty;
      r_rdy_en <= 1'b1;
    end
  end

  fifo_ram #(
    .ADDRB (ADDRB),
    .WID   (WID)
  ) u_ram (
    .clk  (clk),
    .i_we (w_wr_acc && !flush && !rst),
    .i_wa (r_wrptr[ADDRB-1:0]),
    .i_wd (fifodi),
    .i_ra (r_rdptr[ADDRB-1:0]),
    .o_rd (fifodout)
  );

  // Status comes from registered occupancy only; r_rdy_en holds fifordy low
  // through the reset cycle regardless of reqen.
  assign w_free    = DEP_V - r_len;
  assign fifovld   = !w_empty;
  assign fifofull  = w_full;
  assign fifoafull = r_len >= AFTHR_V;
  assign fifordy   = reqen && r_rdy_en && (w_free >= CHK_V);
  assign fifowrerr = r_wrerr;
  assign fiforderr = r_rderr;
  assign fifolen   = r_len;

`ifdef FIFO_PEAK_EN
  logic [ADDRB:0] r_peak;

  // Flush forces w_len_d to zero, so max() alone cannot clear the mark.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_peak <= '0;
    end else if (w_len_d > r_peak) begin
      r_peak <= w_len_d;
    end
  end

  assign fifopeak = r_peak;
`else
  // No high-water tracking in this build.
`endif

endmodule

// File: tb/tb_fifo_rdy_sync.sv
module tb_fifo_rdy_sync;

  localparam int unsigned ADDRB = 5;
  localparam int unsigned WID   = 32;
  localparam int unsigned DEP   = 1 << ADDRB;

  logic           clk = 1'b0;
  logic           rst, fifowr, fifoget, flush, reqen;
  logic [WID-1:0] fifodi;
  logic [WID-1:0] fifodout;
  logic           fifovld, fifordy, fifofull, fifoafull, fifowrerr, fiforderr;
  logic [ADDRB:0] fifolen;
`ifdef FIFO_PEAK_EN
  logic [ADDRB:0] fifopeak;
`endif

  int errors = 0;
  int checks = 0;
  logic [WID-1:0] exp_q [$];

  always #5 clk = ~clk;

  fifo_rdy_sync #(
    .ADDRB (ADDRB),
    .WID   (WID),
    .CHK   (2),
    .AFTHR (DEP - 4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifowr    (fifowr),
    .fifodi    (fifodi),
    .fifoget   (fifoget),
    .flush     (flush),
    .reqen     (reqen),
    .fifodout  (fifodout),
    .fifovld   (fifovld),
    .fifordy   (fifordy),
    .fifofull  (fifofull),
    .fifoafull (fifoafull),
    .fifowrerr (fifowrerr),
    .fiforderr (fiforderr),
    .fifolen   (fifolen)
`ifdef FIFO_PEAK_EN
    ,
    .fifopeak  (fifopeak)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply current inputs at the next edge, then settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [WID-1:0] d);
    fifowr = 1'b1;
    fifodi = d;
    exp_q.push_back(d);
  endtask

  // Scoreboard monitor: every accepted pop is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && !flush && fifoget && fifovld) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 64'(fifodout), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("pop_data", 64'(fifodout), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fifowr = 1'b0; fifoget = 1'b0; flush = 1'b0; reqen = 1'b1; fifodi = '0;
    step();
    step();
    chk("rst_len", 64'(fifolen), 64'd0);
    chk("rst_vld", 64'(fifovld), 64'd0);
    chk("rst_full", 64'(fifofull), 64'd0);
    chk("rst_afull", 64'(fifoafull), 64'd0);
    chk("rst_wrerr", 64'(fifowrerr), 64'd0);
    chk("rst_rderr", 64'(fiforderr), 64'd0);
    chk("rst_rdy", 64'(fifordy), 64'd0);
    rst = 1'b0;
    step();
    chk("rdy_en_empty", 64'(fifordy), 64'd1);
    reqen = 1'b0;
    #1;
    chk("rdy_reqen0", 64'(fifordy), 64'd0);
    reqen = 1'b1;
    #1;
    chk("rdy_reqen1", 64'(fifordy), 64'd1);

    // Single write then pop.
    push_wr(32'hDEADBEEF);
    step();
    fifowr = 1'b0;
    chk("one_vld", 64'(fifovld), 64'd1);
    chk("one_dout", 64'(fifodout), 64'hDEADBEEF);
    chk("one_len", 64'(fifolen), 64'd1);
    fifoget = 1'b1;
    step();
    fifoget = 1'b0;
    chk("one_vld_after", 64'(fifovld), 64'd0);
    chk("one_len_after", 64'(fifolen), 64'd0);

    // Fill to full, checking thresholds at every level.
    for (int i = 0; i < 32; i++) begin
      push_wr(WID'(i));
      step();
      chk("fill_len", 64'(fifolen), 64'(i + 1));
      chk("fill_afull", 64'(fifoafull), 64'((i + 1) >= 28));
      chk("fill_rdy", 64'(fifordy), 64'((i + 1) <= 30));
    end
    fifowr = 1'b0;
    chk("full_flag", 64'(fifofull), 64'd1);
    // Overflow write: dropped, error pulse.
    fifowr = 1'b1;
    fifodi = 32'h0000_0099;
    step();
    fifowr = 1'b0;
    chk("ovf_wrerr", 64'(fifowrerr), 64'd1);
    chk("ovf_len", 64'(fifolen), 64'd32);
    step();
    chk("ovf_wrerr_clr", 64'(fifowrerr), 64'd0);
    // Write+get while full: get happens, write still dropped.
    fifowr = 1'b1;
    fifodi = 32'h0000_0077;
    fifoget = 1'b1;
    step();
    fifowr = 1'b0;
    chk("full_wrget_err", 64'(fifowrerr), 64'd1);
    chk("full_wrget_len", 64'(fifolen), 64'd31);
    for (int i = 0; i < 31; i++) step();
    fifoget = 1'b0;
    chk("drain_len", 64'(fifolen), 64'd0);
    chk("drain_vld", 64'(fifovld), 64'd0);
    chk("drain_q", 64'(exp_q.size()), 64'd0);

    // Underflow.
    fifoget = 1'b1;
    step();
    fifoget = 1'b0;
    chk("udf_rderr", 64'(fiforderr), 64'd1);
    chk("udf_len", 64'(fifolen), 64'd0);
    chk("udf_vld", 64'(fifovld), 64'd0);
    step();
    chk("udf_rderr_clr", 64'(fiforderr), 64'd0);

    // Steady state across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      push_wr(WID'(32'h100 + i));
      step();
    end
    fifoget = 1'b1;
    for (int i = 0; i < 50; i++) begin
      push_wr(WID'(32'h200 + i));
      step();
      chk("steady_len", 64'(fifolen), 64'd10);
    end
    fifowr = 1'b0;
    for (int i = 0; i < 10; i++) step();
    fifoget = 1'b0;
    chk("steady_drain_len", 64'(fifolen), 64'd0);
    chk("steady_q", 64'(exp_q.size()), 64'd0);

    // Flush with a concurrent write.
    for (int i = 0; i < 5; i++) begin
      push_wr(WID'(32'h300 + i));
      step();
    end
    fifowr = 1'b1;
    fifodi = 32'h0000_0BAD;
    flush = 1'b1;
    step();
    flush = 1'b0;
    fifowr = 1'b0;
    exp_q.delete();
    chk("flush_len", 64'(fifolen), 64'd0);
    chk("flush_vld", 64'(fifovld), 64'd0);
    chk("flush_wrerr", 64'(fifowrerr), 64'd0);
    chk("flush_rderr", 64'(fiforderr), 64'd0);
    push_wr(32'h0000_CAFE);
    step();
    fifowr = 1'b0;
    chk("post_flush_dout", 64'(fifodout), 64'h0000_CAFE);
    fifoget = 1'b1;
    step();
    fifoget = 1'b0;
    chk("post_flush_len", 64'(fifolen), 64'd0);

`ifdef FIFO_PEAK_EN
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("peak_flush0", 64'(fifopeak), 64'd0);
    for (int i = 0; i < 7; i++) begin
      push_wr(WID'(32'h400 + i));
      step();
    end
    fifowr = 1'b0;
    fifoget = 1'b1;
    for (int i = 0; i < 7; i++) step();
    fifoget = 1'b0;
    chk("peak_hold", 64'(fifopeak), 64'd7);
    step();
    chk("peak_hold2", 64'(fifopeak), 64'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("peak_clear", 64'(fifopeak), 64'd0);
`endif

    step();
    chk("final_q", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
